// File: rtl/dec_pr_pkg.sv
// Shared types and defaults for the decode-stage posit register file.
// Holds the clear-engine state enum and default geometry.
package dec_pr_pkg;

  typedef enum logic {
    PR_IDLE,
    PR_CLEAR
  } pr_state_e;

  localparam int PR_PW    = 32;
  localparam int PR_NREGS = 32;

endpackage

// File: rtl/dec_pr_scoreboard.sv
// Busy scoreboard for long-latency posit ops.
// Priority per entry: clear-engine wipe, then issue set, then writeback.
module dec_pr_scoreboard
  import dec_pr_pkg::*;
#(
  parameter int NREGS = PR_NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             set_vld,
  input  logic [AW-1:0]    set_addr,
  input  logic [NREGS-1:0] clr_vec,
  input  logic             wipe_vld,
  input  logic [AW-1:0]    wipe_addr,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_d;

  // next busy vector with wipe > set > writeback-clear
  always_comb begin
    busy_d = busy;
    for (int r = 0; r < NREGS; r++) begin
      if (wipe_vld && wipe_addr == AW'(r))
        busy_d[r] = 1'b0;
      else if (set_vld && set_addr == AW'(r))
        busy_d[r] = 1'b1;
      else if (clr_vec[r])
        busy_d[r] = 1'b0;
    end
  end

  // busy register
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) busy <= '0;
    else        busy <= busy_d;
  end

endmodule

// File: rtl/dec_pr_ctl_gen.sv
// Parametrised posit register file with busy scoreboard and clear engine.
// Define DEC_PR_BYPASS_EN to forward same-cycle write data to reads.
module dec_pr_ctl_gen
  import dec_pr_pkg::*;
#(
  parameter int PW      = PR_PW,
  parameter int NREGS   = PR_NREGS,
  parameter int NRD     = 2,
  parameter int NWR     = 1,
  parameter bit ZERO_R0 = 1'b1,
  parameter int AW      = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    scan_mode,
  input  logic [NRD-1:0]          rden,
  input  logic [NRD-1:0][AW-1:0]  raddr,
  output logic [NRD-1:0][PW-1:0]  rd,
  output logic [NRD-1:0]          rd_busy,
  input  logic [NWR-1:0]          wen,
  input  logic [NWR-1:0][AW-1:0]  waddr,
  input  logic [NWR-1:0][PW-1:0]  wd,
  input  logic                    issue_valid,
  input  logic [AW-1:0]           issue_addr,
  output logic [NREGS-1:0]        busy,
  input  logic                    clr_req,
  output logic                    clr_busy,
  output logic                    clr_done
);

  localparam logic [AW:0] CNT_LAST = (AW+1)'(NREGS - 1);

  pr_state_e               state_q, state_d;
  logic [AW:0]             cnt_q, cnt_d;
  logic                    clearing;
  logic [AW-1:0]           wipe_addr;
  logic [NREGS-1:0][PW-1:0] mem;
  logic [NREGS-1:0]        we;
  logic [NREGS-1:0]        wipe;
  logic [NREGS-1:0][PW-1:0] wdat;
  logic                    iss_ok;

  assign clearing  = (state_q == PR_CLEAR);
  assign clr_busy  = clearing;
  assign wipe_addr = cnt_q[AW-1:0];
  assign iss_ok    = issue_valid && !clearing &&
                     !(ZERO_R0 && issue_addr == '0);

  // clear engine next state and done pulse
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_done = 1'b0;
    unique case (state_q)
      PR_IDLE: begin
        if (clr_req) begin
          state_d = PR_CLEAR;
          cnt_d   = '0;
        end
      end
      PR_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d  = PR_IDLE;
          clr_done = 1'b1;
        end
      end
      default: state_d = PR_IDLE;
    endcase
  end

  // clear engine state register
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= PR_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // per-entry write decode; later ports override earlier ones
  always_comb begin
    we   = '0;
    wipe = '0;
    wdat = '0;
    for (int r = 0; r < NREGS; r++) begin
      for (int k = 0; k < NWR; k++) begin
        if (wen[k] && waddr[k] == AW'(r)) begin
          we[r]   = 1'b1;
          wdat[r] = wd[k];
        end
      end
      wipe[r] = clearing && (wipe_addr == AW'(r));
    end
    if (ZERO_R0) we[0] = 1'b0;
    if (clearing) we = '0;
  end

  // storage; scan forces every entry enable open
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      mem <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (scan_mode || we[r] || wipe[r])
          mem[r] <= wipe[r] ? '0 :
                    (we[r] ? wdat[r] : mem[r]);
      end
    end
  end

  // combinational read ports
  always_comb begin
    rd      = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (rden[i]) begin
        rd[i]      = mem[raddr[i]];
        rd_busy[i] = busy[raddr[i]];
`ifdef DEC_PR_BYPASS_EN
        if (we[raddr[i]]) begin
          rd[i]      = wdat[raddr[i]];
          rd_busy[i] = iss_ok && (issue_addr == raddr[i]);
        end
`else
`endif
        if (ZERO_R0 && raddr[i] == '0) rd[i] = '0;
      end
    end
  end

  dec_pr_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb (
    .clk       (clk),
    .rst_l     (rst_l),
    .set_vld   (iss_ok),
    .set_addr  (issue_addr),
    .clr_vec   (we),
    .wipe_vld  (clearing),
    .wipe_addr (wipe_addr),
    .busy      (busy)
  );

endmodule

// File: tb/tb_dec_pr_ctl_gen.sv
// Self-checking bench for dec_pr_ctl_gen.
// Covers default geometry with two write ports plus a small sweep instance.
module tb_dec_pr_ctl_gen;

`ifdef DEC_PR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_l = 1'b1;
  logic scan_mode = 1'b0;

  logic [1:0]       rden;
  logic [1:0][4:0]  raddr;
  logic [1:0][31:0] rd;
  logic [1:0]       rd_busy;
  logic [1:0]       wen;
  logic [1:0][4:0]  waddr;
  logic [1:0][31:0] wd;
  logic             issue_valid;
  logic [4:0]       issue_addr;
  logic [31:0]      busy;
  logic             clr_req, clr_busy, clr_done;

  logic [2:0]       s_rden;
  logic [2:0][2:0]  s_raddr;
  logic [2:0][15:0] s_rd;
  logic [2:0]       s_rd_busy;
  logic [0:0]       s_wen;
  logic [0:0][2:0]  s_waddr;
  logic [0:0][15:0] s_wd;
  logic             s_issue_valid;
  logic [2:0]       s_issue_addr;
  logic [7:0]       s_busy;
  logic             s_clr_req, s_clr_busy, s_clr_done;

  dec_pr_ctl_gen #(
    .PW(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_R0(1'b1)
  ) u0 (
    .clk(clk), .rst_l(rst_l), .scan_mode(scan_mode),
    .rden(rden), .raddr(raddr), .rd(rd), .rd_busy(rd_busy),
    .wen(wen), .waddr(waddr), .wd(wd),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .busy(busy), .clr_req(clr_req),
    .clr_busy(clr_busy), .clr_done(clr_done)
  );

  dec_pr_ctl_gen #(
    .PW(16), .NREGS(8), .NRD(3), .NWR(1), .ZERO_R0(1'b0)
  ) u1 (
    .clk(clk), .rst_l(rst_l), .scan_mode(scan_mode),
    .rden(s_rden), .raddr(s_raddr), .rd(s_rd), .rd_busy(s_rd_busy),
    .wen(s_wen), .waddr(s_waddr), .wd(s_wd),
    .issue_valid(s_issue_valid), .issue_addr(s_issue_addr),
    .busy(s_busy), .clr_req(s_clr_req),
    .clr_busy(s_clr_busy), .clr_done(s_clr_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [63:0] got);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_empty: got %0h expected queued value", got);
    end else begin
      e = exp_q.pop_front();
      chk(e.tag, got, e.val);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic idle;
    rden = '0; raddr = '0; wen = '0; waddr = '0; wd = '0;
    issue_valid = 1'b0; issue_addr = '0; clr_req = 1'b0;
    s_rden = '0; s_raddr = '0; s_wen = '0; s_waddr = '0; s_wd = '0;
    s_issue_valid = 1'b0; s_issue_addr = '0; s_clr_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbusy, ndone, last_done, nz;
    idle();
    #2 rst_l = 1'b0;
    #6;
    rden[0] = 1'b1; raddr[0] = 5'd5;
    push("rst_busy", 0);
    push("rst_clr_busy", 0);
    push("rst_clr_done", 0);
    push("rst_rd", 0);
    settle();
    pop_chk(busy);
    pop_chk(clr_busy);
    pop_chk(clr_done);
    pop_chk(rd[0]);
    @(negedge clk) rst_l = 1'b1;
    tick();

    // write then read back, same-cycle visibility depends on bypass
    idle();
    wen[0] = 1'b1; waddr[0] = 5'd5; wd[0] = 32'h3C00_0000;
    rden[1] = 1'b1; raddr[1] = 5'd5;
    push("t1_same", BYP ? 32'h3C00_0000 : 32'h0);
    settle(); pop_chk(rd[1]);
    tick();
    idle();
    rden[1] = 1'b1; raddr[1] = 5'd5;
    push("t1_next", 32'h3C00_0000);
    settle(); pop_chk(rd[1]);

    // port collision and r0 hardwire
    idle();
    wen = 2'b11; waddr[0] = 5'd7; waddr[1] = 5'd7;
    wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222;
    tick();
    idle();
    rden[0] = 1'b1; raddr[0] = 5'd7;
    push("t2_collide", 32'h2222_2222);
    settle(); pop_chk(rd[0]);
    wen[0] = 1'b1; waddr[0] = 5'd0; wd[0] = 32'hFFFF_FFFF;
    rden[1] = 1'b1; raddr[1] = 5'd0;
    push("t2_r0_same", 0);
    settle(); pop_chk(rd[1]);
    tick();
    idle();
    rden[1] = 1'b1; raddr[1] = 5'd0;
    push("t2_r0_next", 0);
    settle(); pop_chk(rd[1]);

    // scoreboard set / writeback clear
    idle();
    issue_valid = 1'b1; issue_addr = 5'd9;
    tick();
    idle();
    rden[0] = 1'b1; raddr[0] = 5'd9;
    push("t3_busy_set", 32'h0000_0200);
    push("t3_rd_busy", 1);
    settle(); pop_chk(busy); pop_chk(rd_busy[0]);
    wen[0] = 1'b1; waddr[0] = 5'd9; wd[0] = 32'h1234_5678;
    push("t3_rd_busy_wb", BYP ? 1'b0 : 1'b1);
    settle(); pop_chk(rd_busy[0]);
    tick();
    idle();
    push("t3_busy_clr", 0);
    settle(); pop_chk(busy);
    issue_valid = 1'b1; issue_addr = 5'd9;
    wen[1] = 1'b1; waddr[1] = 5'd9; wd[1] = 32'h0000_5555;
    rden[0] = 1'b1; raddr[0] = 5'd9;
    push("t3_rd_busy_iss_wb", BYP ? 1'b1 : 1'b0);
    settle(); pop_chk(rd_busy[0]);
    tick();
    idle();
    rden[0] = 1'b1; raddr[0] = 5'd9;
    push("t3_set_wins", 32'h0000_0200);
    push("t3_data9", 32'h0000_5555);
    settle(); pop_chk(busy); pop_chk(rd[0]);
    wen[0] = 1'b1; waddr[0] = 5'd9; wd[0] = 32'h0000_5555;
    tick();
    idle();
    issue_valid = 1'b1; issue_addr = 5'd0;
    tick();
    idle();
    push("t3_iss_r0", 0);
    settle(); pop_chk(busy);

    // fill, then whole-file clear
    for (int r = 1; r < 32; r++) begin
      idle();
      wen[0] = 1'b1; waddr[0] = 5'(r); wd[0] = 32'hA500_0000 | r;
      if (r == 31) begin
        issue_valid = 1'b1; issue_addr = 5'd3;
      end
      tick();
    end
    idle();
    rden[0] = 1'b1; raddr[0] = 5'd31;
    push("t4_busy_pre", 32'h0000_0008);
    push("t4_fill31", 32'hA500_001F);
    settle(); pop_chk(busy); pop_chk(rd[0]);
    clr_req = 1'b1;
    wen[0] = 1'b1; waddr[0] = 5'd4; wd[0] = 32'hDEAD_BEEF;
    push("t4_clr_busy_req", 0);
    settle(); pop_chk(clr_busy);
    tick();
    nbusy = 0; ndone = 0; last_done = -1;
    for (int c = 0; c < 40; c++) begin
      idle();
      wen[0] = 1'b1; waddr[0] = 5'd20; wd[0] = 32'h7777_7777;
      issue_valid = 1'b1; issue_addr = 5'd21;
      rden[0] = 1'b1; raddr[0] = 5'd31;
      clr_req = (c == 3);
      settle();
      if (!clr_busy) break;
      nbusy++;
      if (clr_done) begin
        ndone++;
        last_done = c;
      end
      if (c == 5) begin
        push("t4_rd_mid", 32'hA500_001F);
        pop_chk(rd[0]);
      end
      tick();
    end
    idle();
    push("t4_nbusy", 32);
    push("t4_ndone", 1);
    push("t4_done_at", 31);
    pop_chk(nbusy); pop_chk(ndone); pop_chk(last_done);
    nz = 0;
    for (int a = 0; a < 32; a++) begin
      rden[0] = 1'b1; raddr[0] = 5'(a);
      settle();
      if (rd[0] != 32'h0) nz++;
    end
    push("t4_nonzero", 0);
    push("t4_busy_post", 0);
    pop_chk(nz); pop_chk(busy);

    // reset in the middle of a clear
    idle();
    wen[0] = 1'b1; waddr[0] = 5'd12; wd[0] = 32'hCAFE_0012;
    tick();
    idle();
    clr_req = 1'b1;
    tick();
    idle();
    repeat (10) tick();
    push("t5_in_clear", 1);
    settle(); pop_chk(clr_busy);
    rst_l = 1'b0;
    rden[0] = 1'b1; raddr[0] = 5'd12;
    push("t5_clr_busy", 0);
    push("t5_clr_done", 0);
    push("t5_rd12", 0);
    settle(); pop_chk(clr_busy); pop_chk(clr_done); pop_chk(rd[0]);
    @(negedge clk) rst_l = 1'b1;
    tick();
    push("t5_idle", 0);
    settle(); pop_chk(clr_busy);

    // sweep instance: 16b x 8, 3 reads, r0 writable
    idle();
    s_wen = 1'b1; s_waddr[0] = 3'd0; s_wd[0] = 16'hBEEF;
    s_issue_valid = 1'b1; s_issue_addr = 3'd0;
    tick();
    idle();
    s_wen = 1'b1; s_waddr[0] = 3'd3; s_wd[0] = 16'h1234;
    tick();
    idle();
    s_wen = 1'b1; s_waddr[0] = 3'd7; s_wd[0] = 16'h0F0F;
    tick();
    idle();
    s_rden = 3'b111;
    s_raddr[0] = 3'd0; s_raddr[1] = 3'd3; s_raddr[2] = 3'd7;
    push("s_rd0", 16'hBEEF);
    push("s_rd1", 16'h1234);
    push("s_rd2", 16'h0F0F);
    push("s_busy0", 8'h01);
    settle();
    pop_chk(s_rd[0]); pop_chk(s_rd[1]); pop_chk(s_rd[2]);
    pop_chk(s_busy);
    s_clr_req = 1'b1;
    tick();
    idle();
    nbusy = 0; ndone = 0;
    for (int c = 0; c < 20; c++) begin
      settle();
      if (!s_clr_busy) break;
      nbusy++;
      if (s_clr_done) ndone++;
      tick();
    end
    s_rden = 3'b001; s_raddr[0] = 3'd0;
    push("s_nbusy", 8);
    push("s_ndone", 1);
    push("s_rd0_clr", 0);
    push("s_busy_clr", 0);
    settle();
    pop_chk(nbusy); pop_chk(ndone); pop_chk(s_rd[0]); pop_chk(s_busy);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
